// File: rtl/seq_detect_param_if.sv
// Serial sample, control and match-result bundle for seq_detect_param.
interface seq_detect_param_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             clear;
  logic             load_pat;
  logic [PAT_W-1:0] pat_in;
  logic             overlap;
  logic             i_valid;
  logic             i;
  logic             o;
  logic             o_reg;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output clear, load_pat, pat_in, overlap, i_valid, i,
    input  o, o_reg, match_cnt
  );

  modport slave (
    input  clear, load_pat, pat_in, overlap, i_valid, i,
    output o, o_reg, match_cnt
  );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-loadable serial pattern detector with Mealy and registered match pulses.
// Optional saturating match counter built when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1101,
  parameter int unsigned      CNT_W   = 8
) (
  input logic              clk,
  input logic              n_rst,
  seq_detect_param_if.slave bus
);
  localparam int unsigned FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic              o_reg;
  logic [PAT_W-1:0]  window;
  logic              accept;
  logic              hit;

  always_comb begin
    window = {hist, bus.i};
    accept = bus.i_valid & ~bus.clear & ~bus.load_pat;
    hit    = accept & (fill == FULL) & (window == pattern);
  end

  assign bus.o     = hit;
  assign bus.o_reg = o_reg;

  // Without overlap the fill count restarts; stale hist bits are masked by fill.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pattern <= PAT_RST;
      hist    <= '0;
      fill    <= '0;
      o_reg   <= 1'b0;
    end else if (bus.clear) begin
      hist    <= '0;
      fill    <= '0;
      o_reg   <= 1'b0;
    end else if (bus.load_pat) begin
      pattern <= bus.pat_in;
      fill    <= '0;
      o_reg   <= 1'b0;
    end else begin
      o_reg <= hit;
      if (bus.i_valid) begin
        hist <= window[PAT_W-2:0];
        if (hit && !bus.overlap)
          fill <= '0;
        else if (fill != FULL)
          fill <= fill + 1'b1;
      end
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      cnt <= '0;
    else if (bus.clear)
      cnt <= '0;
    else if (hit && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

  assign bus.match_cnt = cnt;
`else
  assign bus.match_cnt = '0;
`endif
endmodule
